// File: rtl/kernel_st_adapter_pkg.sv
// rtl/kernel_st_adapter_pkg.sv - shared types and parameter checks for the ST channel filter adapter
// Purpose: packet FSM state encoding and the helper that decides whether an
//          OUT_CHAN_W / MAX_CHANNEL combination is usable.
// Ports:   none (package).
package kernel_st_adapter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // between packets
      ST_PASS = 2'd1,   // inside a packet that is being forwarded
      ST_DROP = 2'd2    // inside a packet that is being discarded
   } pkt_state_e;

   // The output channel must be at least one bit, no wider than the input
   // channel, and wide enough to carry every forwarded channel number.
   function automatic bit chan_cfg_legal(input int in_chan_w,
                                         input int out_chan_w,
                                         input int max_channel);
      return (out_chan_w >= 1) && (out_chan_w <= in_chan_w) &&
             (out_chan_w < 31) && (max_channel >= 0) &&
             (max_channel < (1 << out_chan_w));
   endfunction

endpackage

// File: rtl/kernel_st_skid_buffer.sv
// rtl/kernel_st_skid_buffer.sv - 2-entry registered skid buffer with valid/ready on both sides
// Purpose: decouples upstream ready from downstream ready. s_tready is a flop,
//          so it never depends combinationally on m_tready.
// Ports:   clk, rst          clock, async active-high reset
//          s_tvalid/s_tready/s_tdata   write side (W-bit payload)
//          m_tvalid/m_tready/m_tdata   read side, driven straight from flops
module kernel_st_skid_buffer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_tvalid,
   output logic         s_tready,
   input  logic [W-1:0] s_tdata,
   output logic         m_tvalid,
   input  logic         m_tready,
   output logic [W-1:0] m_tdata
);

   // Entry 0 is always the head; entry 1 only holds data when entry 0 does.
   logic         v0_q, v0_d, v1_q, v1_d;
   logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
   logic         rdy_q, rdy_d;
   logic         push, pop;

   assign push = s_tvalid & rdy_q;
   assign pop  = v0_q & m_tready;

   always_comb begin
      v0_d = v0_q;
      v1_d = v1_q;
      e0_d = e0_q;
      e1_d = e1_q;
      unique case ({push, pop})
         2'b10: begin
            if (!v0_q) begin
               v0_d = 1'b1;
               e0_d = s_tdata;
            end else begin
               v1_d = 1'b1;
               e1_d = s_tdata;
            end
         end
         2'b01: begin
            v0_d = v1_q;
            e0_d = e1_q;
            v1_d = 1'b0;
         end
         // A push implies entry 1 was empty, so the new beat becomes the head.
         2'b11: e0_d = s_tdata;
         default: ;
      endcase
      rdy_d = !(v0_d & v1_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v0_q  <= 1'b0;
         v1_q  <= 1'b0;
         e0_q  <= '0;
         e1_q  <= '0;
         rdy_q <= 1'b0;
      end else begin
         v0_q  <= v0_d;
         v1_q  <= v1_d;
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         rdy_q <= rdy_d;
      end
   end

   assign s_tready = rdy_q;
   assign m_tvalid = v0_q;
   assign m_tdata  = e0_q;

endmodule

// File: rtl/kernel_st_channel_filter_adapter.sv
// rtl/kernel_st_channel_filter_adapter.sv - Avalon-ST channel narrowing and suppression adapter
// Purpose: forwards beats whose channel is <= MAX_CHANNEL with the channel cut
//          to OUT_CHAN_W bits; discards the others per beat (PKT_DROP=0) or
//          per packet decided at SOP (PKT_DROP=1), counting each suppression.
// Ports:   clk, reset                          clock, async active-high reset
//          in_ready/in_valid/in_data/in_channel/in_startofpacket/in_endofpacket   sink side
//          out_ready/out_valid/out_data/out_channel/out_startofpacket/out_endofpacket   source side
//          drop_count   saturating count of suppressed packets/beats
//          drop_pulse   one-cycle pulse per suppression, the cycle after acceptance
module kernel_st_channel_filter_adapter
   import kernel_st_adapter_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int IN_CHAN_W   = 8,
   parameter int OUT_CHAN_W  = 2,
   parameter int MAX_CHANNEL = 3,
   parameter int PKT_DROP    = 1,
   parameter int CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  in_ready,
   input  logic                  in_valid,
   input  logic [DATA_W-1:0]     in_data,
   input  logic [IN_CHAN_W-1:0]  in_channel,
   input  logic                  in_startofpacket,
   input  logic                  in_endofpacket,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [DATA_W-1:0]     out_data,
   output logic [OUT_CHAN_W-1:0] out_channel,
   output logic                  out_startofpacket,
   output logic                  out_endofpacket,
   output logic [CNT_W-1:0]      drop_count,
   output logic                  drop_pulse
);

   localparam int PW = DATA_W + OUT_CHAN_W + 2;

   if (!chan_cfg_legal(IN_CHAN_W, OUT_CHAN_W, MAX_CHANNEL)) begin : g_cfg_check
      $error("kernel_st_channel_filter_adapter: illegal OUT_CHAN_W/MAX_CHANNEL combination");
   end

   pkt_state_e        state_q, state_d;
   logic              drop_pulse_q, drop_pulse_d;
   logic [CNT_W-1:0]  drop_count_q, drop_count_d;
   logic              bad;
   logic              accept;
   logic              drop_beat;
   logic              buf_s_tvalid;
   logic [PW-1:0]     buf_s_tdata, buf_m_tdata;

   // Full-width compare so high channel bits cannot alias into the legal range.
   assign bad    = in_channel > IN_CHAN_W'(MAX_CHANNEL);
   assign accept = in_valid & in_ready;

   always_comb begin
      state_d      = state_q;
      drop_beat    = bad;
      drop_pulse_d = 1'b0;
      if (accept) begin
         if (PKT_DROP == 0) begin
            drop_beat    = bad;
            drop_pulse_d = bad;
         end else if (in_startofpacket) begin
            // SOP always starts a fresh decision, even if the previous EOP was missed.
            drop_beat    = bad;
            drop_pulse_d = bad;
            if (in_endofpacket)
               state_d = ST_IDLE;
            else
               state_d = bad ? ST_DROP : ST_PASS;
         end else begin
            unique case (state_q)
               ST_PASS: begin
                  drop_beat = 1'b0;
                  if (in_endofpacket) state_d = ST_IDLE;
               end
               ST_DROP: begin
                  drop_beat = 1'b1;
                  if (in_endofpacket) state_d = ST_IDLE;
               end
               default: begin
                  // Stray body beat outside a packet: judge it on its own.
                  drop_beat    = bad;
                  drop_pulse_d = bad;
               end
            endcase
         end
      end
      drop_count_d = (drop_pulse_d && (drop_count_q != '1)) ? drop_count_q + 1'b1
                                                             : drop_count_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         drop_pulse_q <= 1'b0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         drop_pulse_q <= drop_pulse_d;
         drop_count_q <= drop_count_d;
      end
   end

   // Suppressed beats are still handshaken upstream; they just skip the buffer write.
   assign buf_s_tvalid = in_valid & ~drop_beat;
   assign buf_s_tdata  = {in_startofpacket, in_endofpacket,
                          in_channel[OUT_CHAN_W-1:0], in_data};

   kernel_st_skid_buffer #(
      .W (PW)
   ) u_skid (
      .clk      (clk),
      .rst      (reset),
      .s_tvalid (buf_s_tvalid),
      .s_tready (in_ready),
      .s_tdata  (buf_s_tdata),
      .m_tvalid (out_valid),
      .m_tready (out_ready),
      .m_tdata  (buf_m_tdata)
   );

   assign {out_startofpacket, out_endofpacket, out_channel, out_data} = buf_m_tdata;
   assign drop_count = drop_count_q;
   assign drop_pulse = drop_pulse_q;

endmodule
